// File: rtl/spi_lcd_tx_if.sv
// Word-push handshake and panel pin bundle for spi_lcd_tx.
interface spi_lcd_tx_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic              i_valid;
    logic              i_dc;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic [LW-1:0]     o_level;
    logic              o_busy;
    logic              o_scl;
    logic              o_sda;
    logic              o_dc;
    logic              o_cs_n;

    modport master (
        output i_valid, i_dc, i_data,
        input  o_ready, o_level, o_busy, o_scl, o_sda, o_dc, o_cs_n
    );

    modport slave (
        input  i_valid, i_dc, i_data,
        output o_ready, o_level, o_busy, o_scl, o_sda, o_dc, o_cs_n
    );
endinterface

// File: rtl/spi_lcd_tx.sv
// SPI transmit engine for the ST7789 path: {DC,payload} FIFO feeding an
// MSB-first serialiser with programmable SCL divider and SPI mode.
module spi_lcd_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 1,
    parameter bit          CPOL       = 1'b1,
    parameter bit          CPHA       = 1'b0
) (
    input  logic         w_clk,
    input  logic         w_rst_n,
    spi_lcd_tx_if.slave  bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned WW    = DATA_W + 1;
    localparam int unsigned EDGES = 2 * DATA_W;
    localparam int unsigned EW    = $clog2(EDGES + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EW-1:0]     edg_q, edg_d;
    logic              scl_q, scl_d, sda_q, sda_d, dc_q, dc_d;
    logic              cs_n_q, cs_n_d, busy_q, busy_d;

    logic          ready, push, pop, tick, last, upd;
    logic [EW-1:0] edge_num;
    logic [WW-1:0] head;

    // Ready comes from the registered count only, so a full FIFO refuses
    // a push even when the engine pops in the same cycle.
    assign ready    = (count_q < LW'(FIFO_DEPTH));
    assign push     = bus.i_valid && ready;
    assign pop      = (state_q == LOAD);
    assign head     = mem_q[rd_ptr_q];
    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign edge_num = edg_q + EW'(1);
    assign last     = (edge_num == EW'(EDGES));

    always_ff @(posedge w_clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.i_dc, bus.i_data};
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + LW'(1);
        else if (!push && pop) count_d = count_q - LW'(1);
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        edg_d   = edg_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        dc_d    = dc_q;
        cs_n_d  = cs_n_q;
        // Mode 0/2 shift after trailing edges (not the final one); mode 1/3 on leading edges.
        upd     = (CPHA == 1'b0) ? (~edge_num[0] & ~last) : edge_num[0];
        unique case (state_q)
            IDLE: if (count_q != '0) state_d = LOAD;
            LOAD: begin
                dc_d   = head[DATA_W];
                cs_n_d = 1'b0;
                div_d  = '0;
                edg_d  = '0;
                if (CPHA == 1'b0) begin
                    sda_d = head[DATA_W-1];
                    sh_d  = {head[DATA_W-2:0], 1'b0};
                end else begin
                    sh_d  = head[DATA_W-1:0];
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    div_d = '0;
                    scl_d = ~scl_q;
                    edg_d = edge_num;
                    if (upd) begin
                        sda_d = sh_q[DATA_W-1];
                        sh_d  = sh_q << 1;
                    end
                    if (last) state_d = (count_q != '0) ? LOAD : GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                cs_n_d = 1'b1;
                scl_d  = CPOL;
                if (tick) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sh_q     <= '0;
            div_q    <= '0;
            edg_q    <= '0;
            scl_q    <= CPOL;
            sda_q    <= 1'b0;
            dc_q     <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sh_q     <= sh_d;
            div_q    <= div_d;
            edg_q    <= edg_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            dc_q     <= dc_d;
            cs_n_q   <= cs_n_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_level = count_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_scl   = scl_q;
    assign bus.o_sda   = sda_q;
    assign bus.o_dc    = dc_q;
    assign bus.o_cs_n  = cs_n_q;
endmodule

// File: tb/tb_spi_lcd_tx.sv
// Bench for spi_lcd_tx: three configurations, pin-level decoder/scoreboard
// checked every cycle, plus literal expectations per directed scenario.
module tb_spi_lcd_tx;
    logic w_clk = 1'b0;
    logic w_rst_n = 1'b0;
    always #5 w_clk = ~w_clk;

    spi_lcd_tx_if #(.DATA_W(8),  .FIFO_DEPTH(4)) b0 ();
    spi_lcd_tx_if #(.DATA_W(8),  .FIFO_DEPTH(4)) b1 ();
    spi_lcd_tx_if #(.DATA_W(16), .FIFO_DEPTH(4)) b2 ();

    spi_lcd_tx #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b0))
        u0 (.w_clk(w_clk), .w_rst_n(w_rst_n), .bus(b0));
    spi_lcd_tx #(.DATA_W(8), .FIFO_DEPTH(4), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b1))
        u1 (.w_clk(w_clk), .w_rst_n(w_rst_n), .bus(b1));
    spi_lcd_tx #(.DATA_W(16), .FIFO_DEPTH(4), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b0))
        u2 (.w_clk(w_clk), .w_rst_n(w_rst_n), .bus(b2));

    int Wk[3] = '{8, 8, 16};
    int Dk[3] = '{2, 1, 2};
    bit Pk[3] = '{1'b1, 1'b0, 1'b1};
    bit Hk[3] = '{1'b0, 1'b1, 1'b0};

    int total = 0;
    int bad   = 0;

    logic [16:0] expq [3][$];
    int pushes[3], starts[3], pos[3], tg[3], nw[3], lowrun[3], highrun[3], last_run[3];
    bit inword[3], saw_full[3];
    logic pscl[3], psda[3], pcs[3], cur_dc[3];
    logic [15:0] sh[3];
    logic [16:0] last_word[3];

    task automatic ck(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic dc, input logic [15:0] d);
        case (k)
            0: begin b0.i_valid = v; b0.i_dc = dc; b0.i_data = d[7:0]; end
            1: begin b1.i_valid = v; b1.i_dc = dc; b1.i_data = d[7:0]; end
            default: begin b2.i_valid = v; b2.i_dc = dc; b2.i_data = d; end
        endcase
    endtask

    task automatic peek(input int k, output logic scl, output logic sda, output logic dc,
                        output logic cs, output logic rdy, output logic busy, output int lvl);
        case (k)
            0: begin scl = b0.o_scl; sda = b0.o_sda; dc = b0.o_dc; cs = b0.o_cs_n;
                     rdy = b0.o_ready; busy = b0.o_busy; lvl = int'(b0.o_level); end
            1: begin scl = b1.o_scl; sda = b1.o_sda; dc = b1.o_dc; cs = b1.o_cs_n;
                     rdy = b1.o_ready; busy = b1.o_busy; lvl = int'(b1.o_level); end
            default: begin scl = b2.o_scl; sda = b2.o_sda; dc = b2.o_dc; cs = b2.o_cs_n;
                     rdy = b2.o_ready; busy = b2.o_busy; lvl = int'(b2.o_level); end
        endcase
    endtask

    task automatic clear(input int k);
        expq[k].delete();
        pushes[k] = 0; starts[k] = 0; pos[k] = 0; tg[k] = 0; nw[k] = 0;
        lowrun[k] = 0; highrun[k] = 1000; inword[k] = 1'b0;
        pscl[k] = Pk[k]; psda[k] = 1'b0; pcs[k] = 1'b1; sh[k] = '0;
    endtask

    task automatic fin(input int k);
        logic [16:0] e, dec;
        inword[k] = 1'b0;
        ck("toggles", tg[k], 2 * Wk[k]);
        dec = {cur_dc[k], sh[k]};
        last_word[k] = dec;
        if (expq[k].size() == 0) ck("word_expected", 0, 1);
        else begin
            e = expq[k].pop_front();
            ck("word", int'(dec), int'(e));
        end
    endtask

    // Pin-level decoder: word windows, edge timing, bit capture, level and busy rules.
    task automatic chk(input int k, input logic scl, input logic sda, input logic dc,
                       input logic cs, input logic rdy, input logic busy, input int lvl);
        int w, d, mlvl;
        bit st, smp, lead;
        w = Wk[k]; d = Dk[k];
        if (!w_rst_n) begin clear(k); return; end
        st = !cs && (pcs[k] || (inword[k] && tg[k] == 2 * w));
        if (cs && !pcs[k] && inword[k]) begin
            fin(k);
            ck("cs_window", lowrun[k], nw[k] * (1 + 2 * w * d));
            last_run[k] = lowrun[k];
        end
        if (st) begin
            if (inword[k]) fin(k);
            if (expq[k].size() == 0) ck("word_expected", 0, 1);
            else cur_dc[k] = expq[k][0][16];
            starts[k]++;
            inword[k] = 1'b1; pos[k] = 0; tg[k] = 0; sh[k] = '0;
            nw[k] = pcs[k] ? 1 : nw[k] + 1;
        end else if (inword[k]) pos[k]++;
        if (scl != pscl[k]) begin
            if (!inword[k] || st) ck("scl_spurious", 0, 1);
            else begin
                tg[k]++;
                ck("scl_timing", pos[k], d * tg[k]);
                smp = Hk[k] ? (scl == Pk[k]) : (scl != Pk[k]);
                if (smp) sh[k] = {sh[k][14:0], sda};
            end
        end
        if (sda != psda[k] && inword[k] && !st) begin
            lead = (scl != pscl[k]) && (scl == (Hk[k] ? !Pk[k] : Pk[k]));
            ck("sda_edge", int'(lead), 1);
        end
        if (cs) ck("scl_idle", int'(scl), int'(Pk[k]));
        if (inword[k]) ck("dc_hold", int'(dc), int'(cur_dc[k]));
        if (cs) highrun[k]++; else highrun[k] = 0;
        if (!cs) lowrun[k] = pcs[k] ? 1 : lowrun[k] + 1;
        mlvl = pushes[k] - starts[k];
        ck("level", lvl, mlvl);
        ck("ready", int'(rdy), int'(mlvl < 4));
        ck("busy", int'(busy), int'(mlvl != 0 || !cs || highrun[k] < d));
        if (lvl == 4 && !rdy) saw_full[k] = 1'b1;
        pscl[k] = scl; psda[k] = sda; pcs[k] = cs;
    endtask

    always begin
        logic s, sd, c, cs, r, b;
        int l;
        @(negedge w_clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            peek(k, s, sd, c, cs, r, b, l);
            chk(k, s, sd, c, cs, r, b, l);
        end
    end

    task automatic push(input int k, input logic dc, input logic [15:0] d);
        logic s, sd, c, cs, r, b;
        int l;
        bit ok;
        ok = 1'b0;
        @(negedge w_clk);
        drive(k, 1'b1, dc, d);
        for (int t = 0; t < 400; t++) begin
            peek(k, s, sd, c, cs, r, b, l);
            @(posedge w_clk);
            if (r) begin
                expq[k].push_back({dc, d});
                pushes[k]++;
                ok = 1'b1;
                break;
            end
            @(negedge w_clk);
        end
        if (!ok) ck("push_timeout", 0, 1);
    endtask

    task automatic release_in(input int k);
        @(negedge w_clk);
        drive(k, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic wait_idle(input int k);
        logic s, sd, c, cs, r, b;
        int l;
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge w_clk);
            #3;
            peek(k, s, sd, c, cs, r, b, l);
            if (!b && l == 0 && cs) begin ok = 1'b1; break; end
        end
        ck("idle_timeout", int'(ok), 1);
        repeat (3) @(negedge w_clk);
    endtask

    task automatic rst_chk(input int k);
        logic s, sd, c, cs, r, b;
        int l;
        peek(k, s, sd, c, cs, r, b, l);
        ck("rst_scl", int'(s), int'(Pk[k]));
        ck("rst_sda", int'(sd), 0);
        ck("rst_dc", int'(c), 0);
        ck("rst_cs_n", int'(cs), 1);
        ck("rst_busy", int'(b), 0);
        ck("rst_level", l, 0);
        ck("rst_ready", int'(r), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0;
        logic pv, s, sd, c, cs, r, b;
        int l;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 1'b0, 16'h0);
            clear(k);
            saw_full[k] = 1'b0;
            last_run[k] = 0;
            last_word[k] = '0;
        end
        repeat (3) @(negedge w_clk);
        #1;
        for (int k = 0; k < 3; k++) rst_chk(k);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        repeat (2) @(negedge w_clk);

        // Single word: 0x2A as a command.
        push(0, 1'b0, 16'h002A);
        release_in(0);
        wait_idle(0);
        ck("single_window", last_run[0], 33);
        ck("single_word", int'(last_word[0]), 32'h0002A);

        // Stream of three words in one chip-select window.
        push(0, 1'b0, 16'h002A);
        push(0, 1'b1, 16'h0000);
        push(0, 1'b1, 16'h00EF);
        release_in(0);
        wait_idle(0);
        ck("stream_window", last_run[0], 99);
        ck("stream_last", int'(last_word[0]), 32'h100EF);

        // Backpressure: six words offered continuously.
        s0 = starts[0];
        saw_full[0] = 1'b0;
        for (int i = 1; i <= 6; i++) push(0, 1'(i & 1), 16'(i * 17));
        release_in(0);
        wait_idle(0);
        ck("bp_full_seen", int'(saw_full[0]), 1);
        ck("bp_words", starts[0] - s0, 6);
        ck("bp_last", int'(last_word[0]), 32'h00066);

        // Mode CPOL=0 CPHA=1 CLK_DIV=1.
        push(1, 1'b1, 16'h00A5);
        release_in(1);
        wait_idle(1);
        ck("mode_window", last_run[1], 17);
        ck("mode_word", int'(last_word[1]), 32'h100A5);

        // 16-bit words.
        push(2, 1'b0, 16'hF800);
        release_in(2);
        wait_idle(2);
        ck("wide_window", last_run[2], 65);
        ck("wide_word", int'(last_word[2]), 32'h0F800);

        // Reset in the middle of a word with two more queued.
        push(0, 1'b1, 16'h0081);
        push(0, 1'b1, 16'h0042);
        push(0, 1'b0, 16'h0024);
        release_in(0);
        pv = b0.o_scl;
        n = 0;
        for (int t = 0; t < 300 && n < 5; t++) begin
            @(negedge w_clk);
            if (b0.o_scl != pv) begin n++; pv = b0.o_scl; end
        end
        ck("rst_mid_reach", n, 5);
        w_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) rst_chk(k);
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
        pv = b0.o_scl;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge w_clk);
            if (b0.o_scl != pv) begin n++; pv = b0.o_scl; end
        end
        peek(0, s, sd, c, cs, r, b, l);
        ck("post_rst_scl_edges", n, 0);
        ck("post_rst_level", l, 0);
        ck("post_rst_cs_n", int'(cs), 1);

        repeat (2) @(negedge w_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_lcd_tx.md
# spi_lcd_tx

Parametrised SPI transmit engine for the ST7789 display path, generalising the fixed 9-bit mode-2 sender. It accepts {DC, payload} words over a valid/ready handshake and buffers them in an internal FIFO. Each word is serialised MSB-first with a programmable SCL divider and a selectable SPI mode. Chip select is generated so that consecutive words stream back-to-back. It sits between the display controller state machines (init/pixel sequencers) and the panel pins.

## Interface
- DATA_W, 8: payload bits per word (4..16).
- FIFO_DEPTH, 4: word buffer depth, power of 2, >=2.
- CLK_DIV, 1: system cycles per SCL half-period, >=1.
- CPOL, 1: SCL idle level.
- CPHA, 0: 0 = data valid before leading edge; 1 = data changes on leading edge.
- w_clk  in  1  system clock (100 MHz); sole clock.
- w_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  word offered.
- i_dc  in  1  D/C bit of offered word (0 command, 1 data).
- i_data  in  DATA_W  payload of offered word.
- o_ready  out  1  FIFO can accept; push occurs on i_valid && o_ready.
- o_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
- o_busy  out  1  high while FIFO non-empty or engine not IDLE.
- o_scl  out  1  SPI clock.
- o_sda  out  1  SPI data, MSB first.
- o_dc  out  1  D/C to panel, held for the whole word.
- o_cs_n  out  1  chip select, active-low.

## Operation
- FIFO stores {i_dc, i_data} (DATA_W+1 bits); o_ready = (o_level < FIFO_DEPTH), registered-count based. Full FIFO blocks push even if a pop occurs in the same cycle.
- Simultaneous push and pop: o_level unchanged; both take effect.
- Engine states: IDLE, LOAD, SHIFT, GAP.
- IDLE: if FIFO non-empty -> LOAD.
- LOAD (1 cycle): pop head; latch o_dc; o_cs_n <= 0; shift register <= payload.
  - CPHA=0: o_sda <= MSB.
  - CPHA=1: o_sda is unchanged until the first edge.
  - Half-period counter and edge counter cleared. -> SHIFT.
- SHIFT: every CLK_DIV cycles o_scl toggles; 2*DATA_W toggles per word.
  - CPHA=0: after each even-numbered (trailing) toggle except the last, o_sda <= next bit.
  - CPHA=1: on each odd-numbered (leading) toggle, o_sda <= next bit.
  - After the last toggle: if FIFO non-empty -> LOAD (o_cs_n stays low); else -> GAP.
- GAP: o_cs_n <= 1, o_scl at CPOL; hold CLK_DIV cycles -> IDLE. A word arriving during GAP waits for IDLE.
- o_scl always returns to CPOL at word end (an even toggle count guarantees this).
- Words are never reordered, dropped or split. o_dc changes only in LOAD.

## Timing
- Reset (async assert, sync release), every output: o_scl=CPOL, o_sda=0, o_dc=0, o_cs_n=1, o_busy=0, o_level=0, o_ready=1. FIFO is emptied and the engine returns to IDLE.
- Reset mid-word: the transfer aborts immediately; partial word is lost; no further SCL edges.
- Latency from push into an empty, idle block to o_cs_n low: 3 cycles (push, IDLE sees non-empty, LOAD).
- Word duration: 1 (LOAD) + 2*DATA_W*CLK_DIV cycles. Back-to-back words add no extra cycles.
- The first SCL toggle occurs CLK_DIV cycles after LOAD.
- o_busy falls in the cycle the engine enters IDLE with an empty FIFO.
- All outputs are registered; no combinational path from inputs to pins except o_ready (from the count register only).

## Test plan
Default parameters (DATA_W=8, CLK_DIV=2, CPOL=1, CPHA=0, FIFO_DEPTH=4) unless noted.
- Single word: push dc=0, data=0x2A. Required: o_cs_n low for 33 cycles, o_dc=0, 16 SCL toggles, sampled on falling edges reads 0,0,1,0,1,0,1,0. Then o_cs_n high for 2 cycles; o_busy=0 afterwards.
- Stream: push 0x2A(dc0), 0x00(dc1), 0xEF(dc1) consecutively. Required: one o_cs_n low window of 99 cycles, o_dc switches only at LOAD cycles, bytes decode in order.
- Backpressure: hold i_valid with 6 distinct words while the engine runs. Required: o_ready low when o_level=4, no lost or duplicated words, o_level never exceeds 4.
- Mode: CPOL=0, CPHA=1, CLK_DIV=1, data 0xA5. Required: SCL idles low; SDA changes on rising edges; sampled on falling edges reads 0xA5; word length 17 cycles.
- Reset mid-word: assert w_rst_n=0 after the 5th SCL toggle with 2 words queued. Required: all outputs at reset values in the same cycle; after release o_level=0 and no SCL activity.
- Width: DATA_W=16, push 0xF800. Required: 32 toggles, decoded 0xF800, word length 1+64 cycles.
